stopwatch_key_conditioner: RTL and testbench

Input conditioning stage that sits directly upstream of the stopwatch control FSM. It takes the raw, bouncing, active-low push-buttons from the board and delivers clean, clock-synchronous signals to the stopwatch's Start, Stop and Rst inputs. Each key is synchronised, debounced by a per-key state machine with a stability counter, and edge-detected. Each key produces a debounced level, a one-cycle press pulse and a one-cycle release pulse.

---
 rtl/stopwatch_key_conditioner.sv | 136 +++++++++++++
 tb/tb_stopwatch_key_conditioner.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_key_conditioner.sv
// Key conditioner for the stopwatch front panel.
// Each raw active-low button is synchronised, debounced by a four-state FSM
// with a stability counter, and turned into a clean level plus press/release pulses.
module stopwatch_key_conditioner #(
    parameter int unsigned N_KEYS          = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [N_KEYS-1:0] KeyN,
    output logic [N_KEYS-1:0] Level,
    output logic [N_KEYS-1:0] Press,
    output logic [N_KEYS-1:0] Release
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMING    = 2'd1,
        ST_HELD      = 2'd2,
        ST_DISARMING = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_KEYS-1:0] sync1_q;
    logic [N_KEYS-1:0] sync2_q;

    state_e            state_q [N_KEYS];
    state_e            state_d [N_KEYS];
    logic [CNT_W-1:0]  cnt_q   [N_KEYS];
    logic [CNT_W-1:0]  cnt_d   [N_KEYS];

    logic [N_KEYS-1:0] level_q,   level_d;
    logic [N_KEYS-1:0] press_q,   press_d;
    logic [N_KEYS-1:0] release_q, release_d;

    // Two-flop synchroniser on the inverted (active-high) raw keys.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= ~KeyN;
            sync2_q <= sync1_q;
        end
    end

    // State, counter and registered outputs for every key.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int unsigned i = 0; i < N_KEYS; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_KEYS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Next-state and counter logic; a change is accepted after DEBOUNCE_CYCLES stable samples.
    always_comb begin
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
            case (state_q[i])
                ST_IDLE: begin
                    if (sync2_q[i]) begin
                        state_d[i] = ST_ARMING;
                        cnt_d[i]   = CNT_W'(1);
                    end else begin
                        state_d[i] = ST_IDLE;
                    end
                end
                ST_ARMING: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = ST_IDLE;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = ST_HELD;
                    end else begin
                        state_d[i] = ST_ARMING;
                        cnt_d[i]   = cnt_q[i] + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = ST_DISARMING;
                        cnt_d[i]   = CNT_W'(1);
                    end else begin
                        state_d[i] = ST_HELD;
                    end
                end
                ST_DISARMING: begin
                    if (sync2_q[i]) begin
                        state_d[i] = ST_HELD;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = ST_IDLE;
                    end else begin
                        state_d[i] = ST_DISARMING;
                        cnt_d[i]   = cnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Outputs derived from the upcoming state so level and pulses register together.
    always_comb begin
        level_d   = '0;
        press_d   = '0;
        release_d = '0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            level_d[i]   = (state_d[i] == ST_HELD) || (state_d[i] == ST_DISARMING);
            press_d[i]   = (state_q[i] == ST_ARMING) && (state_d[i] == ST_HELD);
            release_d[i] = (state_q[i] == ST_DISARMING) && (state_d[i] == ST_IDLE);
        end
    end

    assign Level   = level_q;
    assign Press   = press_q;
    assign Release = release_q;

endmodule

// File: tb/tb_stopwatch_key_conditioner.sv
// Scoreboard bench for stopwatch_key_conditioner with DEBOUNCE_CYCLES=8, N_KEYS=3.
// Stimulus pushes expected pulse events; a monitor pops and compares them.
module tb_stopwatch_key_conditioner;

    localparam int LAT = 10; // 2 sync edges + 8 stable cycles

    logic       Clk;
    logic       Rst_n;
    logic [2:0] KeyN;
    logic [2:0] Level;
    logic [2:0] Press;
    logic [2:0] Release;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         at;
        logic [2:0] press;
        logic [2:0] rel;
        logic [2:0] lvl;
    } ev_t;

    ev_t exp_q[$];
    logic [2:0] prev_lvl = '0;

    stopwatch_key_conditioner #(
        .N_KEYS(3),
        .DEBOUNCE_CYCLES(8),
        .CNT_W(4)
    ) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .KeyN(KeyN),
        .Level(Level),
        .Press(Press),
        .Release(Release)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Edge counter used to timestamp expectations and observations.
    always @(posedge Clk) cyc <= cyc + 1;

    // Monitor: every pulse must match the head of the expectation queue.
    always @(negedge Clk) begin
        ev_t e;
        if (Rst_n) begin
            if ((Press | Release) != 3'b000) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse cyc=%0d press=%b release=%b level=%b", cyc, Press, Release, Level);
                end else begin
                    e = exp_q.pop_front();
                    if (e.at != cyc || e.press !== Press || e.rel !== Release || e.lvl !== Level) begin
                        failures++;
                        $display("FAIL pulse_event got cyc=%0d press=%b release=%b level=%b want cyc=%0d press=%b release=%b level=%b",
                                 cyc, Press, Release, Level, e.at, e.press, e.rel, e.lvl);
                    end
                end
            end else if (Level !== prev_lvl) begin
                checks++;
                failures++;
                $display("FAIL level_change_without_pulse cyc=%0d level=%b prev=%b", cyc, Level, prev_lvl);
            end
        end
        prev_lvl = Level;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic expect_ev(input logic [2:0] p, input logic [2:0] r, input logic [2:0] l);
        ev_t e;
        e.at    = cyc + LAT;
        e.press = p;
        e.rel   = r;
        e.lvl   = l;
        exp_q.push_back(e);
    endtask

    task automatic check_val(input string name, input logic [8:0] got, input logic [8:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%b want=%b", name, got, want);
        end
    endtask

    initial begin
        KeyN  = 3'b111;
        Rst_n = 1'b0;
        wait_cyc(3);
        check_val("reset_outputs", {Level, Press, Release}, 9'b0);
        Rst_n = 1'b1;
        wait_cyc(5);

        // Clean press and release on key 0
        KeyN = 3'b110;
        expect_ev(3'b001, 3'b000, 3'b001);
        wait_cyc(40);
        KeyN = 3'b111;
        expect_ev(3'b000, 3'b001, 3'b000);
        wait_cyc(15);

        // Bounce bursts on key 1, then a settled press
        repeat (4) begin
            KeyN = 3'b101;
            wait_cyc(5);
            KeyN = 3'b111;
            wait_cyc(2);
        end
        KeyN = 3'b101;
        expect_ev(3'b010, 3'b000, 3'b010);
        wait_cyc(20);
        check_val("bounce_level_held", {6'b0, Level}, {6'b0, 3'b010});
        KeyN = 3'b111;
        expect_ev(3'b000, 3'b010, 3'b000);
        wait_cyc(15);

        // All keys together
        KeyN = 3'b000;
        expect_ev(3'b111, 3'b000, 3'b111);
        wait_cyc(20);
        check_val("simul_level_steady", {6'b0, Level}, {6'b0, 3'b111});
        KeyN = 3'b111;
        expect_ev(3'b000, 3'b111, 3'b000);
        wait_cyc(15);

        // Reset while key 2 is arming
        KeyN = 3'b011;
        wait_cyc(6);
        Rst_n = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            check_val("outputs_in_reset_arming", {Level, Press, Release}, 9'b0);
        end
        Rst_n = 1'b1;
        expect_ev(3'b100, 3'b000, 3'b100);
        wait_cyc(20);
        check_val("held_before_reset", {6'b0, Level}, {6'b0, 3'b100});

        // Reset while key 2 is held: level drops without a clock edge
        #2;
        Rst_n = 1'b0;
        #1;
        check_val("async_level_drop", {Level, Press, Release}, 9'b0);
        wait_cyc(2);
        Rst_n = 1'b1;
        expect_ev(3'b100, 3'b000, 3'b100);
        wait_cyc(20);
        KeyN = 3'b111;
        expect_ev(3'b000, 3'b100, 3'b000);
        wait_cyc(15);

        // Long hold on key 0 gives a single press
        KeyN = 3'b110;
        expect_ev(3'b001, 3'b000, 3'b001);
        wait_cyc(1000);
        check_val("long_hold_level", {6'b0, Level}, {6'b0, 3'b001});
        KeyN = 3'b111;
        expect_ev(3'b000, 3'b001, 3'b000);
        wait_cyc(15);

        // Release glitch of 7 cycles while held
        KeyN = 3'b110;
        expect_ev(3'b001, 3'b000, 3'b001);
        wait_cyc(20);
        KeyN = 3'b111;
        wait_cyc(7);
        KeyN = 3'b110;
        repeat (6) begin
            wait_cyc(2);
            check_val("glitch_level_held", {6'b0, Level}, {6'b0, 3'b001});
        end
        wait_cyc(10);
        KeyN = 3'b111;
        expect_ev(3'b000, 3'b001, 3'b000);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge Clk);
        wait_cyc(5);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_pulses outstanding=%0d want=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
